board_state: RTL and testbench

Playfield occupancy store and collision checker for the falling-piece logic. It holds the 10x20 grid of locked cells, each with its 3-bit colour. It continuously checks the five candidate piece positions (left, right, rotate-right, rotate-left, down) against the grid and returns the can_move vector. On get_new_block it writes the active piece into the grid, clears completed rows, and serves per-cell colour lookups for the pixel path.

---
 rtl/board_state.sv | 219 +++++++++++++++++++++
 tb/tb_board_state.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state.sv
// board_state: playfield occupancy store and collision checker.
//
// Holds the COLS x ROWS grid of locked cells (3-bit colour each, 0 = empty).
// A 20-step scan tests the five candidate piece positions against the grid
// and publishes all five results at once on can_move. A get_new_block pulse
// writes the active piece into the grid. The block then walks the rows
// bottom-up, collapsing every full row, and returns to scanning.
//
// Ports
//   Clk, Reset              clock, synchronous active-high reset
//   x_block / y_block       active piece cells (cell i at [5i+4:5i]), locked on get_new_block
//   x/y_move_left/right/down, x/y_rotate_left/right
//                           candidate positions, same packing
//   piece_color             colour written when the piece locks
//   get_new_block           single-cycle lock request (ignored while busy)
//   x_coord / y_coord       cell looked up for cell_color (1-cycle latency)
//   can_move                [4]=left [3]=right [2]=rot-right [1]=rot-left [0]=down, 1 = legal
//   cell_color              registered colour at (x_coord, y_coord), 0 off-grid
//   busy                    lock / line-clear sequence running
//   lines_cleared           rows cleared since reset (wraps)
//   game_over               sticky, row 0 occupied after a lock sequence
module board_state #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] x_block,
    input  logic [19:0] y_block,
    input  logic [19:0] x_move_left,
    input  logic [19:0] y_move_left,
    input  logic [19:0] x_move_right,
    input  logic [19:0] y_move_right,
    input  logic [19:0] x_move_down,
    input  logic [19:0] y_move_down,
    input  logic [19:0] x_rotate_left,
    input  logic [19:0] y_rotate_left,
    input  logic [19:0] x_rotate_right,
    input  logic [19:0] y_rotate_right,
    input  logic [2:0]  piece_color,
    input  logic        get_new_block,
    input  logic [4:0]  x_coord,
    input  logic [4:0]  y_coord,
    output logic [4:0]  can_move,
    output logic [2:0]  cell_color,
    output logic        busy,
    output logic [15:0] lines_cleared,
    output logic        game_over
);
    localparam int              CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int              RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [4:0]      COLS5    = 5'(COLS);
    localparam logic [4:0]      ROWS5    = 5'(ROWS);
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {SCAN, CHECK, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [19:0]   snap_x_q [5];
    logic [19:0]   snap_x_d [5];
    logic [19:0]   snap_y_q [5];
    logic [19:0]   snap_y_d [5];
    logic [4:0]    acc_q, acc_d;
    logic [4:0]    can_move_q, can_move_d;
    logic [2:0]    cell_color_q, cell_color_d;
    logic          busy_q, busy_d;
    logic [15:0]   lines_q, lines_d;
    logic          game_over_q, game_over_d;
    logic [2:0]    grid_q [ROWS][COLS];
    logic [2:0]    grid_d [ROWS][COLS];

    // Candidate order follows the scan: left, right, rot-right, rot-left, down.
    logic [19:0] live_x [5];
    logic [19:0] live_y [5];
    assign live_x[0] = x_move_left;    assign live_y[0] = y_move_left;
    assign live_x[1] = x_move_right;   assign live_y[1] = y_move_right;
    assign live_x[2] = x_rotate_right; assign live_y[2] = y_rotate_right;
    assign live_x[3] = x_rotate_left;  assign live_y[3] = y_rotate_left;
    assign live_x[4] = x_move_down;    assign live_y[4] = y_move_down;

    logic [19:0] cand_x, cand_y;
    logic [4:0]  cell_x, cell_y;
    logic        cell_ok;
    logic        row_full, row_any;
    logic [4:0]  blk_x, blk_y;

    // Cell under test this scan step. At idx 0 the snapshot is being loaded
    // on this same edge, so the live inputs are what the pass must see.
    always_comb begin
        cand_x  = (idx_q == 5'd0) ? live_x[0] : snap_x_q[idx_q[4:2]];
        cand_y  = (idx_q == 5'd0) ? live_y[0] : snap_y_q[idx_q[4:2]];
        cell_x  = cand_x[{3'b0, idx_q[1:0]} * 5'd5 +: 5];
        cell_y  = cand_y[{3'b0, idx_q[1:0]} * 5'd5 +: 5];
        cell_ok = 1'b0;
        if (cell_x < COLS5 && cell_y < ROWS5)
            cell_ok = (grid_q[cell_y[RW-1:0]][cell_x[CW-1:0]] == 3'd0);
    end

    always_comb begin
        row_full = 1'b1;
        row_any  = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (grid_q[row_q][c] == 3'd0) row_full = 1'b0;
            else                          row_any  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        acc_d        = acc_q;
        can_move_d   = can_move_q;
        busy_d       = busy_q;
        lines_d      = lines_q;
        game_over_d  = game_over_q;
        grid_d       = grid_q;
        blk_x        = 5'd0;
        blk_y        = 5'd0;
        cell_color_d = 3'd0;
        if (x_coord < COLS5 && y_coord < ROWS5)
            cell_color_d = grid_q[y_coord[RW-1:0]][x_coord[CW-1:0]];

        case (state_q)
            SCAN: begin
                if (get_new_block) begin
                    for (int i = 0; i < 4; i++) begin
                        blk_x = x_block[5*i +: 5];
                        blk_y = y_block[5*i +: 5];
                        if (blk_x < COLS5 && blk_y < ROWS5)
                            grid_d[blk_y[RW-1:0]][blk_x[CW-1:0]] = piece_color;
                    end
                    can_move_d = 5'd0;
                    busy_d     = 1'b1;
                    row_d      = LAST_ROW;
                    state_d    = CHECK;
                end else begin
                    if (idx_q == 5'd0) begin
                        for (int c = 0; c < 5; c++) begin
                            snap_x_d[c] = live_x[c];
                            snap_y_d[c] = live_y[c];
                        end
                    end
                    // First cell of each candidate restarts its accumulator.
                    acc_d[idx_q[4:2]] = ((idx_q[1:0] == 2'd0) ? 1'b1 : acc_q[idx_q[4:2]]) & cell_ok;
                    if (idx_q == 5'd19) begin
                        can_move_d = {acc_d[0], acc_d[1], acc_d[2], acc_d[3], acc_d[4]};
                        idx_d      = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            CHECK: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (row_q == '0) begin
                    state_d     = SCAN;
                    idx_d       = 5'd0;
                    busy_d      = 1'b0;
                    game_over_d = game_over_q | row_any;
                end else begin
                    row_d = row_q - RW'(1);
                end
            end
            SHIFT: begin
                // Collapse everything above the full row down by one; the row
                // is re-checked because the row that dropped in may be full too.
                for (int r = 1; r < ROWS; r++) begin
                    if (r <= int'(row_q)) grid_d[r] = grid_q[r-1];
                end
                for (int c = 0; c < COLS; c++) grid_d[0][c] = 3'd0;
                lines_d = lines_q + 16'd1;
                state_d = CHECK;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= SCAN;
            idx_q        <= 5'd0;
            row_q        <= '0;
            snap_x_q     <= '{default: '0};
            snap_y_q     <= '{default: '0};
            acc_q        <= 5'd0;
            can_move_q   <= 5'd0;
            cell_color_q <= 3'd0;
            busy_q       <= 1'b0;
            lines_q      <= 16'd0;
            game_over_q  <= 1'b0;
            grid_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            acc_q        <= acc_d;
            can_move_q   <= can_move_d;
            cell_color_q <= cell_color_d;
            busy_q       <= busy_d;
            lines_q      <= lines_d;
            game_over_q  <= game_over_d;
            grid_q       <= grid_d;
        end
    end

    assign can_move      = can_move_q;
    assign cell_color    = cell_color_q;
    assign busy          = busy_q;
    assign lines_cleared = lines_q;
    assign game_over     = game_over_q;
endmodule

// File: tb/tb_board_state.sv
// Testbench for board_state: directed playfield scenarios plus randomized
// locks and candidates, with a cycle-stamped scoreboard of expectations
// produced by a grid-level reference model.
module tb_board_state;
    localparam int K_MOVE = 0, K_COLOR = 1, K_BUSY = 2, K_LINES = 3, K_GO = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [19:0] x_block = '0, y_block = '0;
    logic [19:0] cx [5];
    logic [19:0] cy [5];
    logic [2:0]  piece_color = 3'd0;
    logic        get_new_block = 1'b0;
    logic [4:0]  x_coord = 5'd0, y_coord = 5'd0;
    logic [4:0]  can_move;
    logic [2:0]  cell_color;
    logic        busy;
    logic [15:0] lines_cleared;
    logic        game_over;

    // candidate index: 0 left, 1 right, 2 rot-right, 3 rot-left, 4 down
    board_state #(.COLS(10), .ROWS(20)) dut (
        .Clk(Clk), .Reset(Reset),
        .x_block(x_block), .y_block(y_block),
        .x_move_left(cx[0]), .y_move_left(cy[0]),
        .x_move_right(cx[1]), .y_move_right(cy[1]),
        .x_move_down(cx[4]), .y_move_down(cy[4]),
        .x_rotate_left(cx[3]), .y_rotate_left(cy[3]),
        .x_rotate_right(cx[2]), .y_rotate_right(cy[2]),
        .piece_color(piece_color), .get_new_block(get_new_block),
        .x_coord(x_coord), .y_coord(y_coord),
        .can_move(can_move), .cell_color(cell_color), .busy(busy),
        .lines_cleared(lines_cleared), .game_over(game_over)
    );

    initial forever #10 Clk = ~Clk;

    int cyc = 0;
    initial forever begin
        @(posedge Clk);
        cyc <= cyc + 1;
    end

    typedef struct { int at; int kind; int val; string name; } exp_t;
    exp_t sbq[$];
    int   n_vec = 0, n_err = 0;

    // reference model: playfield as a plain array
    int mg [20][10];
    int m_lines = 0;
    bit m_go = 1'b0;
    int scan_base = 0;

    function automatic void push(int at, int kind, int val, string name);
        exp_t e;
        int   i;
        e.at = at; e.kind = kind; e.val = val; e.name = name;
        i = sbq.size();
        while (i > 0 && sbq[i-1].at > at) i--;
        sbq.insert(i, e);
    endfunction

    // monitor: compares every expectation due at this cycle
    initial forever begin
        exp_t e;
        int   act;
        @(negedge Clk);
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            case (e.kind)
                K_MOVE:  act = int'(can_move);
                K_COLOR: act = int'(cell_color);
                K_BUSY:  act = int'(busy);
                K_LINES: act = int'(lines_cleared);
                default: act = int'(game_over);
            endcase
            n_vec++;
            if (e.at != cyc || act != e.val) begin
                n_err++;
                $display("FAIL %s at cycle %0d: got %0d, expected %0d (due cycle %0d)",
                         e.name, cyc, act, e.val, e.at);
            end
        end
    end

    function automatic void model_reset();
        foreach (mg[r, c]) mg[r][c] = 0;
        m_lines = 0;
        m_go    = 1'b0;
    endfunction

    // Write the piece, drop every full row, return how many rows went.
    function automatic int model_lock(logic [19:0] xb, logic [19:0] yb, int col);
        int tmp [20][10];
        int w, k, x, y;
        bit full, any;
        for (int i = 0; i < 4; i++) begin
            x = int'(xb[5*i +: 5]);
            y = int'(yb[5*i +: 5]);
            if (x < 10 && y < 20) mg[y][x] = col;
        end
        foreach (tmp[r, c]) tmp[r][c] = 0;
        w = 19;
        k = 0;
        for (int r = 19; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (mg[r][c] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int c = 0; c < 10; c++) tmp[w][c] = mg[r][c];
                w--;
            end
        end
        mg = tmp;
        m_lines = (m_lines + k) % 65536;
        any = 1'b0;
        for (int c = 0; c < 10; c++) if (mg[0][c] != 0) any = 1'b1;
        m_go = m_go | any;
        return k;
    endfunction

    function automatic int model_moves();
        int res, x, y;
        bit ok;
        res = 0;
        for (int c = 0; c < 5; c++) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                x = int'(cx[c][5*i +: 5]);
                y = int'(cy[c][5*i +: 5]);
                if (!(x < 10 && y < 20 && mg[y][x] == 0)) ok = 1'b0;
            end
            if (ok) res = res | (1 << (4 - c));
        end
        return res;
    endfunction

    function automatic logic [19:0] pack4(int a, int b, int c, int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_spawn();
        cx[0] = pack4(3, 4, 4, 5); cy[0] = pack4(1, 0, 1, 1);
        cx[1] = pack4(5, 6, 6, 7); cy[1] = pack4(1, 0, 1, 1);
        cx[2] = pack4(5, 5, 5, 4); cy[2] = pack4(0, 1, 2, 1);
        cx[3] = pack4(5, 5, 5, 6); cy[3] = pack4(0, 1, 2, 1);
        cx[4] = pack4(4, 5, 5, 6); cy[4] = pack4(2, 1, 2, 2);
    endtask

    // Expect the model's can_move at the commit of the first pass that
    // starts after the current candidates were applied.
    task automatic check_moves(input string name);
        int m, commit;
        m = (cyc - scan_base + 19) / 20;
        commit = scan_base + 20 * (m + 1);
        push(commit, K_MOVE, model_moves(), name);
        while (cyc < commit) tick();
    endtask

    task automatic read_cell(input int x, input int y, input string name);
        int e;
        x_coord = 5'(x);
        y_coord = 5'(y);
        e = (x < 10 && y < 20) ? mg[y][x] : 0;
        push(cyc + 1, K_COLOR, e, name);
        tick();
    endtask

    task automatic do_lock(input logic [19:0] xb, input logic [19:0] yb, input int col,
                           input bit ign, input bit rst_mid);
        int L, k, done;
        x_block = xb; y_block = yb; piece_color = 3'(col); get_new_block = 1'b1;
        tick();
        get_new_block = 1'b0;
        L = cyc;
        k = model_lock(xb, yb, col);
        push(L, K_BUSY, 1, "busy_on_lock");
        push(L, K_MOVE, 0, "lock_zeroes_can_move");
        if (rst_mid) begin
            tick();                    // row 19 full: SHIFT is next
            Reset = 1'b1;
            model_reset();
            push(L + 2, K_BUSY, 0, "rst_mid_busy");
            push(L + 2, K_LINES, 0, "rst_mid_lines");
            push(L + 2, K_MOVE, 0, "rst_mid_can_move");
            push(L + 2, K_GO, 0, "rst_mid_game_over");
            tick();
            Reset = 1'b0;
            scan_base = cyc;
            return;
        end
        done = L + 20 + 2 * k;
        push(done - 1, K_BUSY, 1, "busy_held");
        push(done, K_BUSY, 0, "busy_fall");
        push(done, K_LINES, m_lines, "lines_cleared");
        push(done, K_GO, int'(m_go), "game_over");
        push(done + 19, K_MOVE, 0, "can_move_zero_till_commit");
        if (ign) begin
            tick();
            x_block = pack4(0, 1, 2, 3); y_block = pack4(0, 0, 0, 0);
            piece_color = 3'd7; get_new_block = 1'b1;
            tick();
            get_new_block = 1'b0;
        end
        while (cyc < done) tick();
        scan_base = done;
    endtask

    initial begin
        logic [19:0] xb, yb;
        int gaps[$];
        int n;
        for (int c = 0; c < 5; c++) begin cx[c] = '0; cy[c] = '0; end
        model_reset();
        repeat (3) tick();
        push(cyc, K_MOVE, 0, "reset_can_move");
        push(cyc, K_BUSY, 0, "reset_busy");
        push(cyc, K_LINES, 0, "reset_lines");
        push(cyc, K_GO, 0, "reset_game_over");
        push(cyc, K_COLOR, 0, "reset_cell_color");
        set_spawn();
        Reset = 1'b0;
        scan_base = cyc;
        push(scan_base + 19, K_MOVE, 0, "no_partial_pass");
        check_moves("spawn_moves");
        cx[0] = pack4(31, 4, 4, 5);
        check_moves("left_wall");
        set_spawn();

        // lock bottom-left I piece, with a pulse while busy that must be ignored
        do_lock(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), 5, 1'b1, 1'b0);
        read_cell(2, 19, "lock_read_2_19");
        read_cell(4, 19, "lock_read_4_19");
        read_cell(0, 0, "ignored_pulse_0_0");
        read_cell(3, 0, "ignored_pulse_3_0");

        // fill row 19 except x=9, with (9,18) colour 3, then complete the row
        do_lock(pack4(4, 5, 6, 7), pack4(19, 19, 19, 19), 2, 1'b0, 1'b0);
        do_lock(pack4(8, 9, 31, 31), pack4(19, 18, 31, 31), 3, 1'b0, 1'b0);
        do_lock(pack4(9, 31, 31, 31), pack4(19, 31, 31, 31), 6, 1'b0, 1'b0);
        read_cell(9, 19, "clear_dropped_9_19");
        for (int x = 0; x < 10; x++) read_cell(x, 0, "clear_row0_empty");
        read_cell(10, 19, "offgrid_x");
        read_cell(3, 20, "offgrid_y");
        cy[4] = pack4(19, 19, 19, 19); cx[4] = pack4(8, 9, 9, 9);
        check_moves("down_into_floor");
        set_spawn();

        // randomized locks and candidates
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) begin
                xb[5*i +: 5] = 5'($urandom_range(0, 9));
                yb[5*i +: 5] = 5'($urandom_range(12, 19));
                if ($urandom_range(0, 7) == 0) xb[5*i +: 5] = 5'($urandom_range(10, 31));
            end
            do_lock(xb, yb, int'($urandom_range(1, 7)), 1'b0, 1'b0);
            for (int c = 0; c < 5; c++)
                for (int i = 0; i < 4; i++) begin
                    cx[c][5*i +: 5] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
                    cy[c][5*i +: 5] = 5'($urandom_range(0, 21));
                end
            check_moves("rand_moves");
            for (int r = 0; r < 3; r++)
                read_cell(int'($urandom_range(0, 11)), int'($urandom_range(10, 21)), "rand_read");
        end

        // game over is sticky
        do_lock(pack4(4, 31, 31, 31), pack4(0, 31, 31, 31), 7, 1'b0, 1'b0);
        do_lock(pack4(0, 31, 31, 31), pack4(8, 31, 31, 31), 4, 1'b0, 1'b0);
        read_cell(4, 0, "top_cell");

        // reset while SHIFT is pending: fill the gaps of row 19, last one with reset
        for (int x = 0; x < 10; x++) if (mg[19][x] == 0) gaps.push_back(x);
        while (gaps.size() > 1) begin
            xb = '1; yb = '1;
            n = (gaps.size() - 1 < 4) ? gaps.size() - 1 : 4;
            for (int i = 0; i < n; i++) begin
                xb[5*i +: 5] = 5'(gaps.pop_front());
                yb[5*i +: 5] = 5'd19;
            end
            do_lock(xb, yb, 1, 1'b0, 1'b0);
        end
        xb = '1; yb = '1;
        xb[4:0] = 5'(gaps.pop_front());
        yb[4:0] = 5'd19;
        do_lock(xb, yb, 2, 1'b0, 1'b1);
        for (int x = 0; x < 10; x++) read_cell(x, 19, "rst_row19_empty");
        read_cell(4, 0, "rst_top_empty");
        set_spawn();
        check_moves("rst_spawn_moves");

        for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            $display("FAIL sb_drain: %0d expectations never reached, first %s due %0d",
                     sbq.size(), sbq[0].name, sbq[0].at);
            n_vec += sbq.size();
            n_err += sbq.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
